jogador_automatico: RTL
=======================

# jogador_automatico

Synthesizable automatic player for the memory-game circuit: drives `iniciar`, `chaves` and `modo` on the player side and watches `acertou`/`errou`/`pronto` from the game core. It replays a fixed play sequence round by round (round r plays entries 0..r), holding each play for a fixed time and releasing it for a fixed gap. The block sits beside `circuito_exp5` on the board, so the game can be self-demonstrated or soak-tested without a human at the switches.

## Interface
- `HOLD`, 10, cycles each play is held on `chaves`
- `GAP`, 20, cycles `chaves`=0 after each play
- `INIT_LEN`, 5, cycles `iniciar` is held high
- `START_WAIT`, 10, idle cycles between `iniciar` falling and the first play
- `TIMEOUT`, 100, cycles allowed in AGUARDA_FIM for `pronto`
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  reset, synchronous and active-low
- `start`  in  1  level, sampled in OCIOSO/FIM_OK/FIM_ERRO
- `modo_sel`  in  1  mode forwarded to the game, latched at start
- `num_rodadas`  in  4  rounds to play, latched at start; 0 is treated as 1
- `acertou`, `errou`, `pronto`  in  1 each  game-core status
- `iniciar`  out  1  start request to the game
- `chaves`  out  4  one-hot play
- `modo`  out  1  latched `modo_sel`
- `ocupado`  out  1  high outside OCIOSO/FIM_OK/FIM_ERRO
- `fim_ok`, `fim_erro`  out  1 each  level result flags
- `db_estado`  out  4  state code
- `db_rodada`  out  4  current round, 0-based

## Operation
- Sequence ROM has 16 entries: entry i = 4'b0001 << (i mod 4). It is indexed by `jogada`, 4 bits.
- States and codes:
  - OCIOSO 0
  - INICIA 1: `iniciar`=1
  - ESPERA_INI 2
  - APERTA 3: `chaves`=ROM[jogada]
  - SOLTA 4: `chaves`=0
  - AGUARDA_FIM 5
  - FIM_OK 6
  - FIM_ERRO 7
- OCIOSO, FIM_OK or FIM_ERRO with `start`=1: latch `modo`/`num_rodadas`, clear `rodada` and `jogada`, clear the result flags, go to INICIA.
- INICIA → ESPERA_INI → APERTA, each after its parameter count.
- APERTA → SOLTA after HOLD cycles.
- At the end of SOLTA (after GAP cycles):
  - if `jogada` < `rodada`: increment `jogada`, go to APERTA;
  - else if `rodada` < N-1: increment `rodada`, clear `jogada`, go to APERTA;
  - else: go to AGUARDA_FIM.
- AGUARDA_FIM:
  - `pronto`&`acertou` → FIM_OK;
  - `pronto`&!`acertou` → FIM_ERRO;
  - TIMEOUT cycles elapsed → FIM_ERRO.
- Aborts, in any state from INICIA through SOLTA:
  - `errou`=1 → FIM_ERRO;
  - `pronto`=1 (premature) → FIM_ERRO.
  - Abort has priority over timer expiry.
- `start` while `ocupado` is ignored.
- One shared timer counts down. It reloads on every state entry, and its width covers the largest parameter.
- Outputs are registered and decoded from next-state, so they change on the same edge as the state.

## Timing
- Reset (`reset`=0 at an edge): state OCIOSO; all outputs 0, including `db_*`, `chaves`, `modo`, `fim_*`. Reset mid-run takes effect at that edge.
- `start` sampled at edge t0:
  - `iniciar`=1 on cycles t0+1 .. t0+INIT_LEN;
  - first `chaves` nonzero at t0+1+INIT_LEN+START_WAIT (default t0+16).
- Each play occupies exactly HOLD+GAP cycles, with no bubble between plays or rounds.
- N rounds: P = N(N+1)/2 plays. AGUARDA_FIM is entered at t0+1+INIT_LEN+START_WAIT+P·(HOLD+GAP).
- Status inputs are sampled each edge. An abort makes `chaves`=0 and `fim_erro`=1 on the next edge.

## Configuration
- `JOGADOR_ERRO_EN`: when defined, adds inputs `erro_en` (1) and `erro_rodada` (4).
  - When `erro_en`=1 and `rodada`==`erro_rodada`, the last play of that round is rotated left by 1 (4'b1000 → 4'b0001).
  - This deliberately provokes `errou` in the game.
- Undefined: those ports do not exist and the ROM is always played verbatim.

## Structure
- Package `jogador_pkg` holds:
  - the state code constants (4-bit);
  - the ROM contents function;
  - the width constant for `db_estado`.
- One sub-module, `temporizador_jogador`: a loadable down-counter with a `fim` flag, used for all waits.
- The FSM, the round/play counters and the ROM stay in `jogador_automatico`.

## Test plan
- Reset with `reset`=0 for 1 cycle mid-APERTA → next edge `chaves`=0, `iniciar`=0, `db_estado`=0, `ocupado`=0.
- `start`, `num_rodadas`=4, game model pulses `pronto`&`acertou` 3 cycles after AGUARDA_FIM entry → expected behaviour:
  - `chaves` sequence 0001 | 0001,0010 | 0001,0010,0100 | 0001,0010,0100,1000;
  - first play at t0+16;
  - AGUARDA_FIM at t0+316;
  - `fim_ok`=1.
- `errou` pulsed during the 2nd play of round 2 → `chaves`=0 and `fim_erro`=1 the next cycle; `start` restarts the run from round 0.
- No `pronto` after the last play → `fim_erro`=1 exactly 100 cycles after AGUARDA_FIM entry.
- `num_rodadas`=0 → exactly one 0001 play, then AGUARDA_FIM at t0+46.
- With `JOGADOR_ERRO_EN`, `erro_en`=1, `erro_rodada`=2 → round 2 plays 0001,0010,1000; rounds 0-1 unchanged.

Source files
------------

// File: rtl/jogador_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jogador_pkg: state codes, debug width and play ROM for the          |
// | automatic player.                                                   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package jogador_pkg;

  localparam int EST_W = 4;

  typedef enum logic [EST_W-1:0] {
    OCIOSO      = 4'd0,
    INICIA      = 4'd1,
    ESPERA_INI  = 4'd2,
    APERTA      = 4'd3,
    SOLTA       = 4'd4,
    AGUARDA_FIM = 4'd5,
    FIM_OK      = 4'd6,
    FIM_ERRO    = 4'd7
  } estado_t;

  // Sequence ROM: entry i lights switch (i mod 4).
  function automatic logic [3:0] rom_jogada(input logic [3:0] idx);
    return 4'b0001 << (idx & 4'd3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jogador_automatico_temporizador.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | temporizador_jogador: loadable down-counter, fim while count is 0.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module temporizador_jogador
  import jogador_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [W-1:0] valor,
  output logic         fim
);

  logic [W-1:0] r_cont;

  always_ff @(posedge clock) begin
    if (!reset)
      r_cont <= '0;
    else if (carrega)
      r_cont <= valor;
    else if (r_cont != '0)
      r_cont <= r_cont - W'(1);
  end

  assign fim = (r_cont == '0);

endmodule
`default_nettype wire

// File: rtl/jogador_automatico.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jogador_automatico: replays the ROM sequence round by round into    |
// | the memory game. Option JOGADOR_ERRO_EN corrupts one chosen round.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int HOLD       = 10,
  parameter int GAP        = 20,
  parameter int INIT_LEN   = 5,
  parameter int START_WAIT = 10,
  parameter int TIMEOUT    = 100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             modo_sel,
  input  logic [3:0]       num_rodadas,
  input  logic             acertou,
  input  logic             errou,
  input  logic             pronto,
`ifdef JOGADOR_ERRO_EN
  input  logic             erro_en,
  input  logic [3:0]       erro_rodada,
`endif
  output logic             iniciar,
  output logic [3:0]       chaves,
  output logic             modo,
  output logic             ocupado,
  output logic             fim_ok,
  output logic             fim_erro,
  output logic [EST_W-1:0] db_estado,
  output logic [3:0]       db_rodada
);

  localparam int c_max_a = (HOLD > GAP) ? HOLD : GAP;
  localparam int c_max_b = (INIT_LEN > START_WAIT) ? INIT_LEN : START_WAIT;
  localparam int c_max_c = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_max   = (c_max_c > TIMEOUT) ? c_max_c : TIMEOUT;
  localparam int c_tmr_w = $clog2(c_max + 1);

  estado_t             r_estado, w_estado_nxt;
  logic [3:0]          r_rodada, w_rodada_nxt, r_jogada, w_jogada_nxt;
  logic [3:0]          r_num, w_ultima, w_play, r_chaves;
  logic                r_modo, r_iniciar, r_ocupado, r_fim_ok, r_fim_erro;
  logic                w_partida, w_aborta, w_fim, w_carrega, w_nxt_livre;
  logic [c_tmr_w-1:0]  w_carga;

  assign w_ultima  = (r_num == 4'd0) ? 4'd0 : r_num - 4'd1;
  assign w_aborta  = errou | pronto;
  assign w_partida = start && (r_estado == OCIOSO || r_estado == FIM_OK ||
                               r_estado == FIM_ERRO);

  always_comb begin
    w_estado_nxt = r_estado;
    w_rodada_nxt = r_rodada;
    w_jogada_nxt = r_jogada;
    case (r_estado)
      OCIOSO, FIM_OK, FIM_ERRO: begin
        if (start) begin
          w_estado_nxt = INICIA;
          w_rodada_nxt = 4'd0;
          w_jogada_nxt = 4'd0;
        end
      end
      INICIA: begin
        if (w_aborta)   w_estado_nxt = FIM_ERRO;
        else if (w_fim) w_estado_nxt = ESPERA_INI;
      end
      ESPERA_INI: begin
        if (w_aborta)   w_estado_nxt = FIM_ERRO;
        else if (w_fim) w_estado_nxt = APERTA;
      end
      APERTA: begin
        if (w_aborta)   w_estado_nxt = FIM_ERRO;
        else if (w_fim) w_estado_nxt = SOLTA;
      end
      SOLTA: begin
        if (w_aborta) begin
          w_estado_nxt = FIM_ERRO;
        end else if (w_fim) begin
          if (r_jogada < r_rodada) begin
            w_jogada_nxt = r_jogada + 4'd1;
            w_estado_nxt = APERTA;
          end else if (r_rodada < w_ultima) begin
            w_rodada_nxt = r_rodada + 4'd1;
            w_jogada_nxt = 4'd0;
            w_estado_nxt = APERTA;
          end else begin
            w_estado_nxt = AGUARDA_FIM;
          end
        end
      end
      AGUARDA_FIM: begin
        if (pronto)     w_estado_nxt = acertou ? FIM_OK : FIM_ERRO;
        else if (w_fim) w_estado_nxt = FIM_ERRO;
      end
      default: w_estado_nxt = OCIOSO;
    endcase
  end

  // Each state holds for exactly its parameter count, hence the minus one.
  always_comb begin
    w_carga = '0;
    case (w_estado_nxt)
      INICIA:      w_carga = c_tmr_w'(INIT_LEN - 1);
      ESPERA_INI:  w_carga = c_tmr_w'(START_WAIT - 1);
      APERTA:      w_carga = c_tmr_w'(HOLD - 1);
      SOLTA:       w_carga = c_tmr_w'(GAP - 1);
      AGUARDA_FIM: w_carga = c_tmr_w'(TIMEOUT - 1);
      default:     w_carga = '0;
    endcase
  end

  assign w_carrega = (w_estado_nxt != r_estado);

  temporizador_jogador #(
    .W(c_tmr_w)
  ) u_temporizador (
    .clock   (clock),
    .reset   (reset),
    .carrega (w_carrega),
    .valor   (w_carga),
    .fim     (w_fim)
  );

  always_comb begin
    w_play = rom_jogada(w_jogada_nxt);
`ifdef JOGADOR_ERRO_EN
    if (erro_en && (w_rodada_nxt == erro_rodada) && (w_jogada_nxt == w_rodada_nxt))
      w_play = {w_play[2:0], w_play[3]};
`endif
  end

  assign w_nxt_livre = (w_estado_nxt == OCIOSO) || (w_estado_nxt == FIM_OK) ||
                       (w_estado_nxt == FIM_ERRO);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_rodada   <= 4'd0;
      r_jogada   <= 4'd0;
      r_num      <= 4'd0;
      r_modo     <= 1'b0;
      r_iniciar  <= 1'b0;
      r_chaves   <= 4'd0;
      r_ocupado  <= 1'b0;
      r_fim_ok   <= 1'b0;
      r_fim_erro <= 1'b0;
    end else begin
      r_estado   <= w_estado_nxt;
      r_rodada   <= w_rodada_nxt;
      r_jogada   <= w_jogada_nxt;
      if (w_partida) begin
        r_modo <= modo_sel;
        r_num  <= num_rodadas;
      end
      r_iniciar  <= (w_estado_nxt == INICIA);
      r_chaves   <= (w_estado_nxt == APERTA) ? w_play : 4'd0;
      r_ocupado  <= !w_nxt_livre;
      r_fim_ok   <= (w_estado_nxt == FIM_OK);
      r_fim_erro <= (w_estado_nxt == FIM_ERRO);
    end
  end

  assign iniciar   = r_iniciar;
  assign chaves    = r_chaves;
  assign modo      = r_modo;
  assign ocupado   = r_ocupado;
  assign fim_ok    = r_fim_ok;
  assign fim_erro  = r_fim_erro;
  assign db_estado = r_estado;
  assign db_rodada = r_rodada;

endmodule
`default_nettype wire
